// File: rtl/adder.sv
// Unsigned ripple-carry adder with a combinational result and a registered,
// valid-flagged copy for pipelined consumers.

module adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic p;

  always_comb begin
    p   = a_i ^ b_i;
    s_o = p ^ c_i;
    c_o = (a_i & b_i) | (c_i & p);
  end

endmodule

module adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic             en,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             valid_q
);

  // c[i] is the carry into bit i; no carry-in, so the chain starts at zero.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
    adder_fa u_fa (
      .a_i (a[i]),
      .b_i (m[i]),
      .c_i (c[i]),
      .s_o (s[i]),
      .c_o (c[i+1])
    );
  end

  assign sum   = s;
  assign carry = c[WIDTH];

  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
  logic             valid_d;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             valid_r;

  // Capture on enable, otherwise hold.
  always_comb begin
    sum_d   = sum_r;
    carry_d = carry_r;
    valid_d = valid_r;
    if (en) begin
      sum_d   = s;
      carry_d = c[WIDTH];
      valid_d = 1'b1;
    end
  end

  // Synchronous reset takes priority over capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r   <= '0;
      carry_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      sum_r   <= sum_d;
      carry_r <= carry_d;
      valid_r <= valid_d;
    end
  end

  assign sum_q   = sum_r;
  assign carry_q = carry_r;
  assign valid_q = valid_r;

endmodule

// File: tb/tb_adder.sv
// Directed self-checking bench for adder at WIDTH=4 and WIDTH=8.

module tb_adder;

  logic       clk;
  logic       rst4, en4;
  logic [3:0] a4, m4, sum4, sum_q4;
  logic       carry4, carry_q4, valid_q4;

  logic       rst8, en8;
  logic [7:0] a8, m8, sum8, sum_q8;
  logic       carry8, carry_q8, valid_q8;

  int n_cmp;
  int n_err;

  adder #(.WIDTH(4)) u_dut4 (
    .clk     (clk),
    .rst     (rst4),
    .a       (a4),
    .m       (m4),
    .en      (en4),
    .sum     (sum4),
    .carry   (carry4),
    .sum_q   (sum_q4),
    .carry_q (carry_q4),
    .valid_q (valid_q4)
  );

  adder #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst     (rst8),
    .a       (a8),
    .m       (m8),
    .en      (en8),
    .sum     (sum8),
    .carry   (carry8),
    .sum_q   (sum_q8),
    .carry_q (carry_q8),
    .valid_q (valid_q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg4(input string tag, input int s, input int c, input int v);
    check({tag, ".sum_q"},   32'(sum_q4),   32'(s));
    check({tag, ".carry_q"}, 32'(carry_q4), 32'(c));
    check({tag, ".valid_q"}, 32'(valid_q4), 32'(v));
  endtask

  // Hand-computed WIDTH=4 vectors: a, m, sum, carry.
  int vec [8][4] = '{
    '{0, 0, 0, 0}, '{9, 6, 15, 0}, '{9, 7, 0, 1}, '{15, 15, 14, 1},
    '{15, 1, 0, 1}, '{8, 7, 15, 0}, '{12, 7, 3, 1}, '{5, 3, 8, 0}
  };

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst4 = 1'b1; en4 = 1'b1; a4 = 4'd5; m4 = 4'd3;
    rst8 = 1'b1; en8 = 1'b0; a8 = 8'd0; m8 = 8'd0;

    // Reset held for two edges with en high; combinational path stays live.
    #1;
    check("rst.comb_pre.sum", 32'(sum4), 32'd8);
    check("rst.comb_pre.carry", 32'(carry4), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check_reg4("rst", 0, 0, 0);
      check("rst.comb.sum", 32'(sum4), 32'd8);
      check("rst.comb.carry", 32'(carry4), 32'd0);
    end

    // Capture 12 + 7.
    rst4 = 1'b0; en4 = 1'b1; a4 = 4'd12; m4 = 4'd7;
    tick();
    check_reg4("cap", 3, 1, 1);

    // Hold for three edges with new inputs on the combinational path.
    en4 = 1'b0; a4 = 4'd1; m4 = 4'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_reg4("hold", 3, 1, 1);
      check("hold.comb.sum", 32'(sum4), 32'd2);
      check("hold.comb.carry", 32'(carry4), 32'd0);
    end

    // Reset asserted between edges must not act until the next edge.
    rst4 = 1'b1; en4 = 1'b1; a4 = 4'd6; m4 = 4'd4;
    #2;
    check_reg4("rst_sync", 3, 1, 1);
    check("rst_sync.comb.sum", 32'(sum4), 32'd10);
    tick();
    check_reg4("rst_mid", 0, 0, 0);

    // Release: next edge captures current inputs.
    rst4 = 1'b0;
    tick();
    check_reg4("release", 10, 0, 1);

    // Ripple worst case with no clock edge involved.
    en4 = 1'b0; a4 = 4'd15; m4 = 4'd0;
    #1;
    check("ripple0.sum", 32'(sum4), 32'd15);
    check("ripple0.carry", 32'(carry4), 32'd0);
    m4 = 4'd1;
    #1;
    check("ripple1.sum", 32'(sum4), 32'd0);
    check("ripple1.carry", 32'(carry4), 32'd1);

    // Directed vectors.
    for (int k = 0; k < 8; k++) begin
      a4 = 4'(vec[k][0]); m4 = 4'(vec[k][1]);
      #1;
      check($sformatf("vec%0d.sum", k), 32'(sum4), 32'(vec[k][2]));
      check($sformatf("vec%0d.carry", k), 32'(carry4), 32'(vec[k][3]));
    end

    // Exhaustive sweep against integer arithmetic.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i); m4 = 4'(j);
        #1;
        check($sformatf("sw%0d+%0d.sum", i, j), 32'(sum4), 32'((i + j) % 16));
        check($sformatf("sw%0d+%0d.carry", i, j), 32'(carry4), 32'((i + j) > 15 ? 1 : 0));
      end
    end

    // WIDTH=8 instance.
    a8 = 8'd200; m8 = 8'd100;
    #1;
    check("w8.200+100.sum", 32'(sum8), 32'd44);
    check("w8.200+100.carry", 32'(carry8), 32'd1);
    a8 = 8'd127; m8 = 8'd128;
    #1;
    check("w8.127+128.sum", 32'(sum8), 32'd255);
    check("w8.127+128.carry", 32'(carry8), 32'd0);
    tick();
    check("w8.rst.valid_q", 32'(valid_q8), 32'd0);
    rst8 = 1'b0; en8 = 1'b1;
    tick();
    check("w8.cap.sum_q", 32'(sum_q8), 32'd255);
    check("w8.cap.carry_q", 32'(carry_q8), 32'd0);
    check("w8.cap.valid_q", 32'(valid_q8), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
